// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD adder/subtractor front end: digit type,
// key indices, entry FSM encoding and the 7-segment patterns used by the
// display stage.
package bcd_pkg;

    // One packed BCD digit; legal values are 0..9.
    typedef logic [3:0] bcd_digit_t;

    // Bit positions of the pushbuttons within KEY.
    localparam int KEY_INC    = 0;
    localparam int KEY_NEXT   = 1;
    localparam int KEY_CLR    = 2;
    localparam int KEY_COMMIT = 3;

    // Entry FSM: EDIT while the user builds operands, HOLD while a committed
    // snapshot waits for the consumer.
    typedef enum logic {
        EDIT = 1'b0,
        HOLD = 1'b1
    } entry_state_t;

    // The single edit action taken in a cycle after priority resolution.
    typedef enum logic [2:0] {
        ACT_NONE   = 3'd0,
        ACT_INC    = 3'd1,
        ACT_NEXT   = 3'd2,
        ACT_CLR    = 3'd3,
        ACT_COMMIT = 3'd4
    } edit_action_t;

    // Active-low 7-segment patterns {g,f,e,d,c,b,a} for digits 0..9.
    localparam logic [6:0] Seg0 = 7'b1000000;
    localparam logic [6:0] Seg1 = 7'b1111001;
    localparam logic [6:0] Seg2 = 7'b0100100;
    localparam logic [6:0] Seg3 = 7'b0110000;
    localparam logic [6:0] Seg4 = 7'b0011001;
    localparam logic [6:0] Seg5 = 7'b0010010;
    localparam logic [6:0] Seg6 = 7'b0000010;
    localparam logic [6:0] Seg7 = 7'b1111000;
    localparam logic [6:0] Seg8 = 7'b0000000;
    localparam logic [6:0] Seg9 = 7'b0010000;

    // Decimal increment of one digit: 9 wraps to 0. Anything out of range is
    // also folded back to 0 so a digit can never leave 0..9.
    function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounce one raw active-low pushbutton and emit a single-cycle pulse when
// the button becomes stably pressed. Release produces no pulse.
// DEBOUNCE_CYCLES must be at least 2 and 2**CNT_W must exceed it.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic key_n,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_meta;
    logic             sync_q;
    logic             stable_q;
    logic [CNT_W-1:0] cnt_q;

    // Two-flop synchronizer; resets to "released" so reset release is quiet.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, regardless of statement order.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            sync_meta <= 1'b1;
            sync_q    <= 1'b1;
        end else begin
            sync_meta <= key_n;
            sync_q    <= sync_meta;
        end
    end

    // Count consecutive samples that disagree with the accepted level; after
    // DEBOUNCE_CYCLES of them the new level is accepted. A 1->0 acceptance
    // fires the press pulse in the same edge as the level flip.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press    <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_q != stable_q) begin
                if (cnt_q == CNT_LAST) begin
                    stable_q <= sync_q;
                    cnt_q    <= '0;
                    press    <= stable_q & ~sync_q;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/bcd_operand_entry.sv
// Pushbutton operand entry for the two-digit BCD adder/subtractor. Four
// debounced keys edit a live 4-digit working value {A10,A1,B10,B1}; a commit
// snapshots it (plus the add/sub select) and offers it downstream through a
// VALID/READY handshake.
module bcd_operand_entry
    import bcd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic [3:0]  KEY,
    input  logic        OP_SUB_IN,
    input  logic        READY,
    output logic [15:0] EDIT_DIGITS,
    output logic [1:0]  CURSOR,
    output logic [7:0]  A_BCD,
    output logic [7:0]  B_BCD,
    output logic        OP_SUB,
    output logic        VALID
);

    logic [3:0]   press;
    edit_action_t action;
    entry_state_t state_q;
    entry_state_t state_d;
    logic         load_snap;

    // Working digits indexed by cursor position: 0=A10, 1=A1, 2=B10, 3=B1.
    bcd_digit_t   digit_q [4];
    logic [1:0]   cursor_q;

    logic [7:0]   a_q;
    logic [7:0]   b_q;
    logic         op_q;

    // One conditioner per pushbutton.
    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_key_debounce (
            .CLOCK_50 (CLOCK_50),
            .RESET    (RESET),
            .key_n    (KEY[k]),
            .press    (press[k])
        );
    end

    // Resolve coincident presses to one action: clear > commit > next > inc.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        action = ACT_NONE;
        if (press[KEY_CLR]) begin
            action = ACT_CLR;
        end else if (press[KEY_COMMIT]) begin
            action = ACT_COMMIT;
        end else if (press[KEY_NEXT]) begin
            action = ACT_NEXT;
        end else if (press[KEY_INC]) begin
            action = ACT_INC;
        end
    end

    // Entry FSM state register.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q <= EDIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Entry FSM next state: commit is honoured only in EDIT; HOLD leaves on
    // the handshake. A commit seen in HOLD is dropped, not queued.
    always_comb begin
        state_d   = state_q;
        load_snap = 1'b0;
        case (state_q)
            EDIT: begin
                if (action == ACT_COMMIT) begin
                    state_d   = HOLD;
                    load_snap = 1'b1;
                end
            end
            HOLD: begin
                if (READY) begin
                    state_d = EDIT;
                end
            end
            default: begin
                state_d = EDIT;
            end
        endcase
    end

    // Working digits and cursor follow the resolved edit action in any state.
    // NOTE: the digit array is only four small registers, so it is reset like
    // any other state; a large RAM-style array would be left unreset instead.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= '0;
            end
            cursor_q <= 2'd0;
        end else begin
            case (action)
                ACT_INC: begin
                    digit_q[cursor_q] <= bcd_inc(digit_q[cursor_q]);
                end
                ACT_NEXT: begin
                    cursor_q <= cursor_q + 2'd1;
                end
                ACT_CLR: begin
                    for (int i = 0; i < 4; i++) begin
                        digit_q[i] <= '0;
                    end
                    cursor_q <= 2'd0;
                end
                default: begin
                end
            endcase
        end
    end

    // Committed snapshot; held constant for the whole of HOLD and kept after
    // the transfer until the next commit.
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            a_q  <= 8'h00;
            b_q  <= 8'h00;
            op_q <= 1'b0;
        end else if (load_snap) begin
            a_q  <= {digit_q[0], digit_q[1]};
            b_q  <= {digit_q[2], digit_q[3]};
            op_q <= OP_SUB_IN;
        end
    end

    // VALID is decoded straight from the state flop so RESET drops it at once.
    assign VALID       = (state_q == HOLD);
    assign EDIT_DIGITS = {digit_q[0], digit_q[1], digit_q[2], digit_q[3]};
    assign CURSOR      = cursor_q;
    assign A_BCD       = a_q;
    assign B_BCD       = b_q;
    assign OP_SUB      = op_q;

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Self-checking bench for bcd_operand_entry with a short debounce window.
// Expected values come from a decimal model of the operand-entry rules.
module tb_bcd_operand_entry;

    localparam int DEB = 4;

    logic        CLOCK_50;
    logic        RESET;
    logic [3:0]  KEY;
    logic        OP_SUB_IN;
    logic        READY;
    logic [15:0] EDIT_DIGITS;
    logic [1:0]  CURSOR;
    logic [7:0]  A_BCD;
    logic [7:0]  B_BCD;
    logic        OP_SUB;
    logic        VALID;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: plain decimal digits and a pending flag.
    int m_dig [4];
    int m_cur;
    bit m_valid;
    int m_a_dec;
    int m_b_dec;
    bit m_op;

    bcd_operand_entry #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (3)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET       (RESET),
        .KEY         (KEY),
        .OP_SUB_IN   (OP_SUB_IN),
        .READY       (READY),
        .EDIT_DIGITS (EDIT_DIGITS),
        .CURSOR      (CURSOR),
        .A_BCD       (A_BCD),
        .B_BCD       (B_BCD),
        .OP_SUB      (OP_SUB),
        .VALID       (VALID)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_dig[i] = 0;
        m_cur   = 0;
        m_valid = 0;
        m_a_dec = 0;
        m_b_dec = 0;
        m_op    = 0;
    endtask

    // Net effect of one press operation (keys in mask pressed together, READY
    // and OP_SUB_IN held for the whole operation).
    task automatic model_apply(input logic [3:0] mask, input logic rdy, input logic ops);
        if (rdy) m_valid = 0;
        if (mask[2]) begin
            for (int i = 0; i < 4; i++) m_dig[i] = 0;
            m_cur = 0;
        end else if (mask[3]) begin
            if (!m_valid) begin
                m_a_dec = 10 * m_dig[0] + m_dig[1];
                m_b_dec = 10 * m_dig[2] + m_dig[3];
                m_op    = ops;
                m_valid = 1;
            end
        end else if (mask[1]) begin
            m_cur = (m_cur + 1) % 4;
        end else if (mask[0]) begin
            m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
        end
        if (rdy) m_valid = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".digits"}, 32'(EDIT_DIGITS),
              32'({4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2]), 4'(m_dig[3])}));
        check({tag, ".cursor"}, 32'(CURSOR), 32'(m_cur));
        check({tag, ".valid"},  32'(VALID),  32'(m_valid));
        check({tag, ".a"},      32'(A_BCD),  32'(to_bcd(m_a_dec)));
        check({tag, ".b"},      32'(B_BCD),  32'(to_bcd(m_b_dec)));
        check({tag, ".op"},     32'(OP_SUB), 32'(m_op));
    endtask

    // Hold the keys in mask low for 8 cycles, release for 8, then compare.
    task automatic press_op(input string tag, input logic [3:0] mask,
                            input logic rdy, input logic ops);
        @(negedge CLOCK_50);
        READY     = rdy;
        OP_SUB_IN = ops;
        KEY       = ~mask;
        repeat (8) @(negedge CLOCK_50);
        KEY = 4'hF;
        repeat (8) @(negedge CLOCK_50);
        model_apply(mask, rdy, ops);
        check_state(tag);
    endtask

    initial begin
        logic [3:0] mask;
        logic       rdy;
        int         pick;

        RESET     = 1'b1;
        KEY       = 4'hF;
        OP_SUB_IN = 1'b0;
        READY     = 1'b0;
        model_reset();

        // 1. Reset state, then a quiet stretch after release.
        repeat (3) @(negedge CLOCK_50);
        check_state("reset");
        RESET = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLOCK_50);
            check("idle.digits", 32'(EDIT_DIGITS), 32'h0);
            check("idle.valid", 32'(VALID), 32'h0);
        end
        check("idle.cursor", 32'(CURSOR), 32'h0);

        // 2. First increment with latency check: applied DEB+3 edges after
        //    the raw falling edge (pulse after DEB+2, action one edge later).
        @(negedge CLOCK_50);
        KEY[0] = 1'b0;
        repeat (DEB + 2) @(negedge CLOCK_50);
        check("lat.before", 32'(EDIT_DIGITS), 32'h0000);
        @(negedge CLOCK_50);
        check("lat.after", 32'(EDIT_DIGITS), 32'h1000);
        @(negedge CLOCK_50);
        KEY[0] = 1'b1;
        repeat (8) @(negedge CLOCK_50);
        model_apply(4'b0001, 1'b0, 1'b0);
        check_state("inc1");
        for (int i = 0; i < 11; i++) press_op("inc", 4'b0001, 1'b0, 1'b0);
        check("inc12.a10", 32'(EDIT_DIGITS[15:12]), 32'h2);
        // Short glitch must be filtered.
        @(negedge CLOCK_50);
        KEY[0] = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        KEY[0] = 1'b1;
        repeat (12) @(negedge CLOCK_50);
        check_state("glitch");

        // 3. Enter 47 and 85 from a cleared value, then commit and hand over.
        press_op("clr", 4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) press_op("e47", 4'b0001, 1'b0, 1'b0);
        press_op("nxt", 4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) press_op("e47", 4'b0001, 1'b0, 1'b0);
        press_op("nxt", 4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) press_op("e85", 4'b0001, 1'b0, 1'b0);
        press_op("nxt", 4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) press_op("e85", 4'b0001, 1'b0, 1'b0);
        press_op("commit", 4'b1000, 1'b0, 1'b0);
        check("commit.a", 32'(A_BCD), 32'h47);
        check("commit.b", 32'(B_BCD), 32'h85);
        check("commit.valid", 32'(VALID), 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            check("hold.valid", 32'(VALID), 32'h1);
            check("hold.a", 32'(A_BCD), 32'h47);
            check("hold.b", 32'(B_BCD), 32'h85);
        end
        READY = 1'b1;
        @(negedge CLOCK_50);
        READY = 1'b0;
        check("xfer.valid", 32'(VALID), 32'h0);
        m_valid = 0;

        // 4. Edits in HOLD change working digits; a second commit is ignored.
        press_op("commit2", 4'b1000, 1'b0, 1'b0);
        press_op("hold.inc", 4'b0001, 1'b0, 1'b0);
        check("hold.b1", 32'(EDIT_DIGITS[3:0]), 32'h6);
        press_op("hold.commit", 4'b1000, 1'b0, 1'b1);
        check("hold.keep_a", 32'(A_BCD), 32'h47);
        check("hold.keep_b", 32'(B_BCD), 32'h85);
        check("hold.keep_op", 32'(OP_SUB), 32'h0);
        check("hold.keep_valid", 32'(VALID), 32'h1);
        press_op("hold.ready", 4'b0000, 1'b1, 1'b0);

        // 5. Clear and increment together: clear wins, increment dropped.
        press_op("clr+inc", 4'b0101, 1'b0, 1'b0);
        check("clr+inc.digits", 32'(EDIT_DIGITS), 32'h0000);

        // Random press sequences, occasionally several keys at once.
        for (int n = 0; n < 40; n++) begin
            pick = int'($urandom_range(0, 15));
            if (pick < 12) mask = 4'(1 << (pick % 4));
            else           mask = 4'($urandom_range(1, 15));
            rdy = ($urandom_range(0, 3) == 0);
            press_op("rand", mask, rdy, 1'($urandom_range(0, 1)));
        end

        // 6. Reset while a snapshot is pending.
        press_op("pre.clr", 4'b0100, 1'b0, 1'b0);
        press_op("pre.inc", 4'b0001, 1'b0, 1'b0);
        press_op("pre.nxt", 4'b0010, 1'b0, 1'b0);
        press_op("pre.inc", 4'b0001, 1'b0, 1'b0);
        if (m_valid) press_op("pre.ready", 4'b0000, 1'b1, 1'b0);
        press_op("pre.commit", 4'b1000, 1'b0, 1'b1);
        check("pre.valid", 32'(VALID), 32'h1);
        @(negedge CLOCK_50);
        RESET = 1'b1;
        #1;
        check("rst.valid", 32'(VALID), 32'h0);
        check("rst.a", 32'(A_BCD), 32'h00);
        check("rst.b", 32'(B_BCD), 32'h00);
        check("rst.cursor", 32'(CURSOR), 32'h0);
        check("rst.digits", 32'(EDIT_DIGITS), 32'h0000);
        @(negedge CLOCK_50);
        RESET = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) @(negedge CLOCK_50);
        check_state("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
